// File: rtl/pair_cfg_sched_if.sv
// pair_cfg_sched_if: shadow-config write bus, commit request and packet issue handshake.
interface pair_cfg_sched_if;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cmt_req;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_1;
    logic [31:0] pkt_2;
    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cmt_req, pkt_valid, pkt_1, pkt_2,
        input  pkt_ready
    );
    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cmt_req, pkt_valid, pkt_1, pkt_2,
        output pkt_ready
    );
endinterface

// File: rtl/pair_cfg_sched.sv
// pair_cfg_sched: shadow/active config banks for the pair atom, drain-before-commit, packet issue gating.
// Optional feature macro PAIR_CFG_READBACK_EN adds a registered shadow readback port.
module pair_cfg_sched #(
    parameter int PIPE_DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pair_cfg_sched_if.slave  bus,
    output logic             o__cmt_ack,
    output logic             o__cfg_err,
    output logic [7:0]       o__cfg_epoch,
    output logic [31:0]      o__pkt_1,
    output logic [31:0]      o__pkt_2,
    output logic [639:0]     o__cons_flat,
    output logic [71:0]      o__sel_flat,
    output logic [7:0]       o__rel_flat,
    output logic [7:0]       o__arith_flat,
    input  logic [31:0]      i__read_1,
    input  logic [31:0]      i__read_2,
    output logic             o__res_valid,
    output logic [31:0]      o__res_1,
    output logic [31:0]      o__res_2
`ifdef PAIR_CFG_READBACK_EN
    ,
    input  logic [4:0]       i__cfg_raddr,
    output logic [31:0]      o__cfg_rdata
`endif
);
    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
    state_t state, state_nxt;
    // misc word layout: [71:0] selectors, [79:72] rel ops, [87:80] arith ops
    logic [31:0]           sh_cons [20];
    logic [31:0]           ac_cons [20];
    logic [87:0]           sh_misc, ac_misc;
    logic [PIPE_DEPTH-1:0] inflight;
    logic                  issue;
    assign issue = bus.pkt_valid && bus.pkt_ready;
    // Shadow bank writes; illegal addresses only raise the sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_cons    <= '{default: '0};
            sh_misc    <= '0;
            o__cfg_err <= 1'b0;
        end else if (bus.cfg_we) begin
            if (bus.cfg_addr < 5'd20) sh_cons[bus.cfg_addr] <= bus.cfg_wdata;
            else if (bus.cfg_addr == 5'd20) sh_misc[31:0] <= bus.cfg_wdata;
            else if (bus.cfg_addr == 5'd21) sh_misc[63:32] <= bus.cfg_wdata;
            else if (bus.cfg_addr == 5'd22) sh_misc[87:64] <= bus.cfg_wdata[23:0];
            else o__cfg_err <= 1'b1;
        end
    end
    // Active bank takes the pre-write shadow in the swap cycle and bumps the epoch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_cons      <= '{default: '0};
            ac_misc      <= '0;
            o__cfg_epoch <= '0;
        end else if (state == SWAP) begin
            ac_cons      <= sh_cons;
            ac_misc      <= sh_misc;
            o__cfg_epoch <= o__cfg_epoch + 8'd1;
        end
    end
    // Packet registers, in-flight tracker and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight     <= '0;
            o__pkt_1     <= '0;
            o__pkt_2     <= '0;
            o__res_valid <= 1'b0;
            o__res_1     <= '0;
            o__res_2     <= '0;
        end else begin
            inflight     <= PIPE_DEPTH'({inflight, issue});
            o__res_valid <= inflight[PIPE_DEPTH-1];
            if (issue) begin
                o__pkt_1 <= bus.pkt_1;
                o__pkt_2 <= bus.pkt_2;
            end
            if (inflight[PIPE_DEPTH-1]) begin
                o__res_1 <= i__read_1;
                o__res_2 <= i__read_2;
            end
        end
    end
    // Commit FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else state <= state_nxt;
    end
    // Commit FSM next state and handshake outputs; requests outside RUN are dropped
    always_comb begin
        state_nxt     = RUN;
        bus.pkt_ready = 1'b0;
        o__cmt_ack    = 1'b0;
        state_nxt     = (state == RUN)   ? (bus.cmt_req ? DRAIN : RUN) :
                        (state == DRAIN) ? ((inflight == '0) ? SWAP : DRAIN) : RUN;
        bus.pkt_ready = (state == RUN);
        o__cmt_ack    = (state == SWAP);
    end
    // Flatten the active bank onto the atom configuration buses
    always_comb begin
        o__cons_flat = '0;
        for (int i = 0; i < 20; i++) o__cons_flat[32*i +: 32] = ac_cons[i];
        o__sel_flat   = ac_misc[71:0];
        o__rel_flat   = ac_misc[79:72];
        o__arith_flat = ac_misc[87:80];
    end
`ifdef PAIR_CFG_READBACK_EN
    // Registered shadow readback; a same-cycle write is not yet visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o__cfg_rdata <= '0;
        else o__cfg_rdata <= (i__cfg_raddr < 5'd20)  ? sh_cons[i__cfg_raddr] :
                             (i__cfg_raddr == 5'd20) ? sh_misc[31:0] :
                             (i__cfg_raddr == 5'd21) ? sh_misc[63:32] :
                             (i__cfg_raddr == 5'd22) ? {8'h00, sh_misc[87:64]} : 32'h0;
    end
`endif
endmodule

// File: tb/tb_pair_cfg_sched.sv
// tb_pair_cfg_sched: directed scoreboard bench for pair_cfg_sched with PIPE_DEPTH=3 and a delay-line atom model.
module tb_pair_cfg_sched;
    localparam int P = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    pair_cfg_sched_if bus ();
    logic         cmt_ack, cfg_err, res_valid;
    logic [7:0]   epoch, rel_flat, arith_flat;
    logic [31:0]  pkt_1, pkt_2, read_1, read_2, res_1, res_2;
    logic [639:0] cons_flat;
    logic [71:0]  sel_flat;
`ifdef PAIR_CFG_READBACK_EN
    logic [4:0]   raddr = '0;
    logic [31:0]  rdata;
`endif
    pair_cfg_sched #(.PIPE_DEPTH(P)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .o__cmt_ack(cmt_ack), .o__cfg_err(cfg_err), .o__cfg_epoch(epoch),
        .o__pkt_1(pkt_1), .o__pkt_2(pkt_2),
        .o__cons_flat(cons_flat), .o__sel_flat(sel_flat),
        .o__rel_flat(rel_flat), .o__arith_flat(arith_flat),
        .i__read_1(read_1), .i__read_2(read_2),
        .o__res_valid(res_valid), .o__res_1(res_1), .o__res_2(res_2)
`ifdef PAIR_CFG_READBACK_EN
        , .i__cfg_raddr(raddr), .o__cfg_rdata(rdata)
`endif
    );
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_r1[$], exp_r2[$];
    logic [7:0]  exp_ack[$];
    // Atom model: read results appear P cycles after issue (o__pkt is visible one cycle after issue)
    logic [31:0] d1 [P-1], d2 [P-1];
    always @(posedge clk) begin
        d1[0] <= pkt_1;
        d2[0] <= pkt_2;
        for (int i = 1; i < P - 1; i++) begin
            d1[i] <= d1[i-1];
            d2[i] <= d2[i-1];
        end
    end
    assign read_1 = d1[P-2] + 32'd1;
    assign read_2 = d2[P-2] ^ 32'hFFFF_FFFF;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Monitor: ack checked before results so a result coinciding with the ack is caught
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmt_ack) begin
                if (exp_ack.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
                else begin
                    chk("ack_epoch", 32'(epoch), 32'(exp_ack.pop_front()));
                    chk("ack_after_results", 32'(exp_r1.size()), 32'd0);
                end
            end
            if (res_valid) begin
                if (exp_r1.size() == 0) chk("unexpected_res", 32'd1, 32'd0);
                else begin
                    chk("res_1", res_1, exp_r1.pop_front());
                    chk("res_2", res_2, exp_r2.pop_front());
                end
            end
        end
    end
    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_wdata = d;
        go(1);
        bus.cfg_we = 1'b0;
    endtask
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bus.pkt_valid = 1'b1;
        bus.pkt_1 = a;
        bus.pkt_2 = b;
        chk("issue_ready", 32'(bus.pkt_ready), 32'd1);
        exp_r1.push_back(a + 32'd1);
        exp_r2.push_back(b ^ 32'hFFFF_FFFF);
        go(1);
        bus.pkt_valid = 1'b0;
    endtask
    task automatic wait_ack(input string nm);
        int n = 0;
        while (!cmt_ack && n < 30) begin
            go(1);
            n++;
        end
        chk(nm, 32'(cmt_ack), 32'd1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.cmt_req = 1'b0;
        bus.pkt_valid = 1'b0; bus.pkt_1 = '0; bus.pkt_2 = '0;
        go(2);
        rst_n = 1'b1;
        go(1);
        chk("rst_cons", cons_flat[31:0], 32'h0);
        chk("rst_sel", sel_flat[31:0], 32'h0);
        chk("rst_rel_arith", {16'h0, rel_flat, arith_flat}, 32'h0);
        chk("rst_ready", 32'(bus.pkt_ready), 32'd1);
        chk("rst_epoch", 32'(epoch), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        // Commit with an empty pipe: ack at N+2, ready again at N+3
        wr(5'd0, 32'h0000_0005);
        wr(5'd22, 32'h00FF_0300);
        bus.cmt_req = 1'b1;
        exp_ack.push_back(8'd0);
        chk("req_cycle_ready", 32'(bus.pkt_ready), 32'd1);
        go(1);
        bus.cmt_req = 1'b0;
        chk("n1_ready", 32'(bus.pkt_ready), 32'd0);
        chk("n1_ack", 32'(cmt_ack), 32'd0);
        go(1);
        chk("n2_ack", 32'(cmt_ack), 32'd1);
        chk("n2_cons_old", cons_flat[31:0], 32'h0);
        go(1);
        chk("n3_ready", 32'(bus.pkt_ready), 32'd1);
        chk("c1_epoch", 32'(epoch), 32'd1);
        chk("c1_cons1", cons_flat[31:0], 32'h5);
        chk("c1_rel", 32'(rel_flat), 32'h03);
        chk("c1_arith", 32'(arith_flat), 32'hFF);
        chk("c1_sel33", 32'(sel_flat[71:64]), 32'h0);
        // Three back-to-back packets, commit in the third; results precede the ack
        wr(5'd1, 32'h77);
        send(32'h1000_0001, 32'h2000_0001);
        send(32'h1000_0002, 32'h2000_0002);
        bus.cmt_req = 1'b1;
        exp_ack.push_back(8'd1);
        send(32'h1000_0003, 32'h2000_0003);
        bus.cmt_req = 1'b0;
        chk("drain_ready", 32'(bus.pkt_ready), 32'd0);
        chk("pkt_1_reg", pkt_1, 32'h1000_0003);
        chk("pkt_2_reg", pkt_2, 32'h2000_0003);
        n = 0;
        while (!cmt_ack && n < 30) begin
            chk("cons2_hold", cons_flat[63:32], 32'h0);
            go(1);
            n++;
        end
        chk("c2_ack_seen", 32'(cmt_ack), 32'd1);
        chk("c2_cons2_at_ack", cons_flat[63:32], 32'h0);
        go(1);
        chk("c2_cons2", cons_flat[63:32], 32'h77);
        chk("c2_epoch", 32'(epoch), 32'd2);
        // Illegal address: sticky error, no shadow change
        wr(5'd25, 32'hDEAD_BEEF);
        chk("err_set", 32'(cfg_err), 32'd1);
`ifdef PAIR_CFG_READBACK_EN
        raddr = 5'd25;
        go(1);
        chk("rb_illegal", rdata, 32'h0);
        raddr = 5'd22;
        go(1);
        chk("rb_word22", rdata, 32'h00FF_0300);
`endif
        bus.cmt_req = 1'b1;
        exp_ack.push_back(8'd2);
        go(1);
        bus.cmt_req = 1'b0;
        wait_ack("c3_ack");
        go(1);
        chk("err_sticky", 32'(cfg_err), 32'd1);
        chk("c3_epoch", 32'(epoch), 32'd3);
        chk("c3_cons1", cons_flat[31:0], 32'h5);
        chk("c3_cons2", cons_flat[63:32], 32'h77);
        chk("c3_sel_lo", sel_flat[31:0], 32'h0);
        chk("c3_sel_hi", sel_flat[63:32], 32'h0);
        // Shadow write in the SWAP cycle misses that swap, lands in the next
        bus.cmt_req = 1'b1;
        exp_ack.push_back(8'd3);
        go(1);
        bus.cmt_req = 1'b0;
        go(1);
        chk("c4_swap_ack", 32'(cmt_ack), 32'd1);
        wr(5'd5, 32'h0000_ABCD);
        chk("c4_cons6_old", cons_flat[191:160], 32'h0);
        chk("c4_epoch", 32'(epoch), 32'd4);
        bus.cmt_req = 1'b1;
        exp_ack.push_back(8'd4);
        go(1);
        bus.cmt_req = 1'b0;
        wait_ack("c5_ack");
        go(1);
        chk("c5_cons6_new", cons_flat[191:160], 32'h0000_ABCD);
        chk("c5_epoch", 32'(epoch), 32'd5);
        // Second request during DRAIN is ignored: one ack only
        bus.cmt_req = 1'b1;
        exp_ack.push_back(8'd5);
        send(32'h3000_0000, 32'h4000_0000);
        chk("c6_drain_ready", 32'(bus.pkt_ready), 32'd0);
        go(1);
        bus.cmt_req = 1'b0;
        wait_ack("c6_ack");
        go(1);
        chk("c6_epoch", 32'(epoch), 32'd6);
        go(6);
        chk("c6_no_second", 32'(epoch), 32'd6);
        chk("c6_ready", 32'(bus.pkt_ready), 32'd1);
        // Reset mid-DRAIN aborts the commit and clears everything
        wr(5'd2, 32'h1234);
        send(32'h5000_0001, 32'h6000_0001);
        bus.cmt_req = 1'b1;
        send(32'h5000_0002, 32'h6000_0002);
        bus.cmt_req = 1'b0;
        chk("rst_drain_ready", 32'(bus.pkt_ready), 32'd0);
        rst_n = 1'b0;
        exp_r1.delete();
        exp_r2.delete();
        #1;
        chk("abort_ack", 32'(cmt_ack), 32'd0);
        chk("abort_ready", 32'(bus.pkt_ready), 32'd1);
        chk("abort_epoch", 32'(epoch), 32'd0);
        chk("abort_err", 32'(cfg_err), 32'd0);
        chk("abort_cons1", cons_flat[31:0], 32'h0);
        chk("abort_cons6", cons_flat[191:160], 32'h0);
        chk("abort_ops", {16'h0, rel_flat, arith_flat}, 32'h0);
        chk("abort_pkt_1", pkt_1, 32'h0);
        chk("abort_res", {31'h0, res_valid} | res_1, 32'h0);
        go(2);
        rst_n = 1'b1;
        go(8);
        chk("post_rst_epoch", 32'(epoch), 32'd0);
        bus.cmt_req = 1'b1;
        exp_ack.push_back(8'd0);
        go(1);
        bus.cmt_req = 1'b0;
        wait_ack("post_rst_ack");
        go(1);
        chk("post_rst_epoch1", 32'(epoch), 32'd1);
        chk("post_rst_cons3", cons_flat[95:64], 32'h0);
        chk("post_rst_cons6", cons_flat[191:160], 32'h0);
        go(5);
        chk("res_queue_empty", 32'(exp_r1.size()), 32'd0);
        chk("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
